// File: rtl/qspi_master_pkg.sv
// qspi_master_pkg: FSM states and SPI-NOR opcodes for the flash master.
// QSPI_FAST_READ_DUMMY_EN adds the DUMMY state used by fast read.
package qspi_master_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_CMD,
    ST_ADDR,
`ifdef QSPI_FAST_READ_DUMMY_EN
    ST_DUMMY,
`endif
    ST_WRITE,
    ST_READ,
    ST_CS_HOLD,
    ST_CS_GAP
  } st_e;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] CMD_PP        = 8'h02;
  localparam logic [7:0] CMD_WREN      = 8'h06;
  localparam logic [7:0] CMD_RDSR      = 8'h05;
  localparam logic [7:0] CMD_RDID      = 8'h9F;

endpackage

// File: rtl/qspi_clk_strobe.sv
// qspi_clk_strobe: divides sd_clk into qspi_clk half-periods of CLK_DIV
// cycles; rise/fall flag the last cycle before qspi_clk toggles.
module qspi_clk_strobe #(
  parameter int CLK_DIV = 2
) (
  input  logic sd_clk,
  input  logic rst,
  input  logic en,
  output logic rise,
  output logic fall,
  output logic qspi_clk
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          ph;
  logic          last;

  assign last     = (cnt == CW'(CLK_DIV - 1));
  assign rise     = en & last & ~ph;
  assign fall     = en & last & ph;
  assign qspi_clk = ph;

  // Disabled means parked at the start of a low half.
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ph  <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      ph  <= 1'b0;
    end else if (last) begin
      cnt <= '0;
      ph  <= ~ph;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/qspi_master_engine.sv
// qspi_master_engine: single-lane mode-0 SPI master for the flash pins.
// Define QSPI_FAST_READ_DUMMY_EN for dummy clocks after a 0x0B address.
module qspi_master_engine
  import qspi_master_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int DUMMY_CYCLES = 8,
  parameter int CS_GAP       = 4
) (
  input  logic        sd_clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [23:0] addr,
  input  logic        has_addr,
  input  logic [15:0] wr_len,
  input  logic [15:0] rd_len,
  input  logic [7:0]  wr_data,
  output logic        wr_req,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic        qspi_clk,
  output logic        qspi_csn,
  output logic        qspi_di,
  input  logic        qspi_do,
  output logic        qspi_wpn,
  output logic        qspi_holdn
);

  localparam int BW =
    (DUMMY_CYCLES > 24) ? $clog2(DUMMY_CYCLES + 1) : 5;

  st_e           state, state_n;
  st_e           unit_nxt, data_nxt;
  logic [23:0]   addr_q;
  logic          has_addr_q;
`ifdef QSPI_FAST_READ_DUMMY_EN
  logic          fast_q;
`endif
  logic [15:0]   wr_left, rd_left, wait_cnt;
  logic [BW-1:0] bit_left;
  logic [31:0]   tx;
  logic [7:0]    rx;
  logic          shifting, sclk_en;
  logic          rise, fall, unit_end;

  assign busy     = (state != ST_IDLE);
  assign shifting = busy && state != ST_CS_SETUP &&
                    state != ST_CS_HOLD && state != ST_CS_GAP;
  assign sclk_en  = shifting || state == ST_CS_SETUP;
  assign unit_end = fall && shifting && bit_left == BW'(1);

  // A new write byte goes straight to the pin while it is fetched.
  assign qspi_di    = wr_req ? wr_data[7] : tx[31];
  assign qspi_wpn   = 1'b1;
  assign qspi_holdn = 1'b1;

  qspi_clk_strobe #(.CLK_DIV(CLK_DIV)) u_strobe (
    .sd_clk   (sd_clk),
    .rst      (rst),
    .en       (sclk_en),
    .rise     (rise),
    .fall     (fall),
    .qspi_clk (qspi_clk)
  );

  always_comb begin
    data_nxt = ST_CS_HOLD;
    if (wr_left != 16'd0)
      data_nxt = ST_WRITE;
    else if (rd_left != 16'd0)
      data_nxt = ST_READ;
    unit_nxt = data_nxt;
    if (state == ST_CMD && has_addr_q)
      unit_nxt = ST_ADDR;
`ifdef QSPI_FAST_READ_DUMMY_EN
    if (state == ST_ADDR && fast_q)
      unit_nxt = ST_DUMMY;
`endif
    state_n = state;
    unique case (state)
      ST_IDLE:     if (start) state_n = ST_CS_SETUP;
      ST_CS_SETUP: if (rise) state_n = ST_CMD;
      ST_CS_HOLD:  if (wait_cnt == 16'd0) state_n = ST_CS_GAP;
      ST_CS_GAP:   if (wait_cnt == 16'd0) state_n = ST_IDLE;
      default:     if (unit_end) state_n = unit_nxt;
    endcase
  end

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      has_addr_q <= 1'b0;
`ifdef QSPI_FAST_READ_DUMMY_EN
      fast_q     <= 1'b0;
`endif
      wr_left    <= '0;
      rd_left    <= '0;
      wait_cnt   <= '0;
      bit_left   <= '0;
      tx         <= '0;
      rx         <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      wr_req     <= 1'b0;
      done       <= 1'b0;
      qspi_csn   <= 1'b1;
    end else begin
      wr_req   <= 1'b0;
      rd_valid <= 1'b0;
      done     <= (state == ST_CS_GAP) && (state_n == ST_IDLE);
      qspi_csn <= (state_n == ST_IDLE) || (state_n == ST_CS_GAP);

      if (state == ST_IDLE && start) begin
        addr_q     <= addr;
        has_addr_q <= has_addr;
`ifdef QSPI_FAST_READ_DUMMY_EN
        fast_q     <= has_addr && cmd == CMD_FAST_READ;
`endif
        wr_left    <= wr_len;
        rd_left    <= rd_len;
        tx         <= {cmd, 24'h0};
        bit_left   <= BW'(8);
      end

      if (wr_req)
        tx <= {wr_data, 24'h0};

      if (rise && state == ST_READ) begin
        rx <= {rx[6:0], qspi_do};
        if (bit_left == BW'(1)) begin
          rd_data  <= {rx[6:0], qspi_do};
          rd_valid <= 1'b1;
        end
      end

      if (fall && shifting) begin
        if (bit_left != BW'(1)) begin
          tx       <= {tx[30:0], 1'b0};
          bit_left <= bit_left - 1'b1;
        end else begin
          tx       <= '0;
          bit_left <= BW'(8);
          case (state_n)
            ST_ADDR: begin
              tx       <= {addr_q, 8'h0};
              bit_left <= BW'(24);
            end
`ifdef QSPI_FAST_READ_DUMMY_EN
            ST_DUMMY: bit_left <= BW'(DUMMY_CYCLES);
`endif
            ST_WRITE: begin
              wr_req  <= 1'b1;
              wr_left <= wr_left - 1'b1;
            end
            ST_READ: rd_left <= rd_left - 1'b1;
            default: ;
          endcase
        end
      end

      if (state != ST_CS_HOLD && state_n == ST_CS_HOLD)
        wait_cnt <= 16'(CLK_DIV - 1);
      else if (state == ST_CS_HOLD && state_n == ST_CS_GAP)
        wait_cnt <= 16'(CS_GAP - 1);
      else if (wait_cnt != 16'd0)
        wait_cnt <= wait_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_qspi_master_engine.sv
// tb_qspi_master_engine: directed frames against a mode-0 flash model.
// Honours QSPI_FAST_READ_DUMMY_EN when picking fast-read expectations.
module tb_qspi_master_engine;
  import qspi_master_pkg::*;

  localparam int CS_GAP = 4;
`ifdef QSPI_FAST_READ_DUMMY_EN
  localparam int FR_PRE   = 40;
  localparam int FR_EDGES = 48;
`else
  localparam int FR_PRE   = 32;
  localparam int FR_EDGES = 40;
`endif

  logic        sd_clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cmd = '0;
  logic [23:0] addr = '0;
  logic        has_addr = 1'b0;
  logic [15:0] wr_len = '0;
  logic [15:0] rd_len = '0;
  logic [7:0]  wr_data;
  logic        wr_req, rd_valid, busy, done;
  logic [7:0]  rd_data;
  logic        qspi_clk, qspi_csn, qspi_di, qspi_wpn, qspi_holdn;
  logic        qspi_do;

  int n_tests = 0;
  int n_fail = 0;

  logic [7:0]  wbuf [0:3];
  int          widx = 0;
  bit          wpend = 1'b0;
  logic [63:0] rstream = '0;
  int          pre = 0;
  int          nrdbits = 0;
  int          bitpos = 0;

  bit          mosi [0:255];
  logic [7:0]  rdq [0:7];
  int nrise = 0, nrd = 0, nwreq = 0, ndone = 0, nframes = 0;
  int gap = 0, min_gap = 1000;
  logic clk_prev = 1'b0, csn_prev = 1'b1;

  always #5 sd_clk = ~sd_clk;

  qspi_master_engine #(
    .CLK_DIV(2), .DUMMY_CYCLES(8), .CS_GAP(CS_GAP)
  ) dut (
    .sd_clk     (sd_clk),
    .rst        (rst),
    .start      (start),
    .cmd        (cmd),
    .addr       (addr),
    .has_addr   (has_addr),
    .wr_len     (wr_len),
    .rd_len     (rd_len),
    .wr_data    (wr_data),
    .wr_req     (wr_req),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .done       (done),
    .qspi_clk   (qspi_clk),
    .qspi_csn   (qspi_csn),
    .qspi_di    (qspi_di),
    .qspi_do    (qspi_do),
    .qspi_wpn   (qspi_wpn),
    .qspi_holdn (qspi_holdn)
  );

  assign wr_data = wbuf[widx[1:0]];

  // Flash model: shifts MISO out on falling qspi_clk.
  always @(negedge qspi_csn) bitpos = 0;
  always @(negedge qspi_clk) bitpos = bitpos + 1;
  always_comb begin
    qspi_do = 1'b0;
    if (bitpos >= pre && bitpos < pre + nrdbits)
      qspi_do = rstream[63 - (bitpos - pre)];
  end

  always @(negedge sd_clk) begin
    if (qspi_clk && !clk_prev && !qspi_csn) begin
      if (nrise < 256) mosi[nrise] = qspi_di;
      nrise++;
    end
    clk_prev = qspi_clk;
    if (!qspi_csn && csn_prev) begin
      nframes++;
      if (gap < min_gap) min_gap = gap;
    end
    gap = qspi_csn ? gap + 1 : 0;
    csn_prev = qspi_csn;
    if (rd_valid) begin
      if (nrd < 8) rdq[nrd] = rd_data;
      nrd++;
    end
    if (wpend) widx++;
    wpend = wr_req;
    if (wr_req) nwreq++;
    if (done) ndone++;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mosi_byte(input int b);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[6:0], mosi[8*b+i]};
    return r;
  endfunction

  task automatic kick(input logic [7:0] c, input logic [23:0] a,
                      input logic ha, input logic [15:0] wl,
                      input logic [15:0] rl);
    cmd = c; addr = a; has_addr = ha; wr_len = wl; rd_len = rl;
    nrise = 0; nrd = 0; nwreq = 0; ndone = 0; nframes = 0;
    widx = 0; wpend = 1'b0;
    start = 1'b1;
    @(negedge sd_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge sd_clk);
      seen = done;
    end
    #1;
    check({tag, "_done"}, 64'(seen), 64'd1);
  endtask

  initial begin
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;

    repeat (3) @(negedge sd_clk);
    rst = 1'b0;
    repeat (5) @(negedge sd_clk);
    rst = 1'b1;
    #1;
    check("rst_pins", {qspi_csn, qspi_clk, qspi_di, qspi_wpn, qspi_holdn},
          64'b10011);
    check("rst_flags", {busy, done, wr_req, rd_valid}, 64'd0);
    check("rst_rdata", rd_data, 64'd0);
    @(negedge sd_clk);
    rst = 1'b0;
    @(negedge sd_clk);

    rstream = {8'hEF, 8'h40, 8'h18, 40'h0}; pre = 8; nrdbits = 24;
    kick(CMD_RDID, 24'h0, 1'b0, 16'd0, 16'd3);
    wait_done("rdid", 2000);
    check("rdid_cmd", mosi_byte(0), 64'h9F);
    check("rdid_rd_mosi", mosi_byte(1), 64'h00);
    check("rdid_edges", nrise, 64'd32);
    check("rdid_nrd", nrd, 64'd3);
    check("rdid_bytes", {rdq[0], rdq[1], rdq[2]}, 64'hEF4018);
    check("rdid_ndone", ndone, 64'd1);
    check("rdid_busy", busy, 64'd0);

    nrdbits = 0;
    kick(CMD_PP, 24'h001000, 1'b1, 16'd4, 16'd0);
    wait_done("pp", 2000);
    check("pp_edges", nrise, 64'd64);
    check("pp_mosi_hdr",
          {mosi_byte(0), mosi_byte(1), mosi_byte(2), mosi_byte(3)},
          64'h02001000);
    check("pp_mosi_dat",
          {mosi_byte(4), mosi_byte(5), mosi_byte(6), mosi_byte(7)},
          64'h11223344);
    check("pp_wreq", nwreq, 64'd4);
    check("pp_nrd", nrd, 64'd0);

    kick(CMD_WREN, 24'h0, 1'b0, 16'd0, 16'd0);
    wait_done("wren", 1000);
    check("wren_edges", nrise, 64'd8);
    check("wren_mosi", mosi_byte(0), 64'h06);
    check("wren_wreq", nwreq, 64'd0);

    rstream = {8'h5A, 56'h0}; pre = 8; nrdbits = 8;
    kick(CMD_RDSR, 24'h0, 1'b0, 16'd0, 16'd1);
    repeat (6) @(negedge sd_clk);
    check("ign_busy", busy, 64'd1);
    cmd = CMD_WREN;
    start = 1'b1;
    @(negedge sd_clk);
    start = 1'b0;
    wait_done("ign", 1000);
    check("ign_frames", nframes, 64'd1);
    check("ign_edges", nrise, 64'd16);
    check("ign_byte", rdq[0], 64'h5A);
    min_gap = 1000;
    kick(CMD_RDSR, 24'h0, 1'b0, 16'd0, 16'd1);
    wait_done("b2b", 1000);
    check("b2b_frames", nframes, 64'd1);
    check("b2b_byte", rdq[0], 64'h5A);
    check("b2b_gap_ok", 64'(min_gap >= CS_GAP), 64'd1);

    nrdbits = 0;
    kick(CMD_PP, 24'h000100, 1'b1, 16'd4, 16'd0);
    for (int k = 0; k < 1000 && nwreq < 2; k++) begin
      @(negedge sd_clk);
      #1;
    end
    check("rstw_in_write", 64'(nwreq >= 2), 64'd1);
    rst = 1'b1;
    #1;
    check("rstw_pins", {qspi_csn, qspi_clk}, 64'b10);
    check("rstw_flags", {busy, wr_req, rd_valid}, 64'd0);
    @(negedge sd_clk);
    rst = 1'b0;
    @(negedge sd_clk);
    rstream = {8'hEF, 8'h40, 8'h18, 40'h0}; pre = 8; nrdbits = 24;
    kick(CMD_RDID, 24'h0, 1'b0, 16'd0, 16'd3);
    wait_done("post_rst", 2000);
    check("post_rst_edges", nrise, 64'd32);
    check("post_rst_bytes", {rdq[0], rdq[1], rdq[2]}, 64'hEF4018);

    rstream = {8'hA5, 56'h0}; pre = FR_PRE; nrdbits = 8;
    kick(CMD_FAST_READ, 24'h0, 1'b1, 16'd0, 16'd1);
    wait_done("fast", 2000);
    check("fast_edges", nrise, 64'(FR_EDGES));
    check("fast_nrd", nrd, 64'd1);
    check("fast_byte", rdq[0], 64'hA5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
